// File: rtl/seg_scan_mux_if.sv
// ----------------------------------------------------------------------------
// seg_scan_mux_if
//   Bundles the host-side load bus and the board-side segment/common pins of
//   seg_scan_mux so both ends can be connected with one port.
//
//   master : host / testbench side (drives the load bus, observes outputs)
//   slave  : seg_scan_mux side
//
//   Signals
//     data_in   DATA_W    binary value, sampled on an accepted load
//     load      1         one-cycle start strobe, taken only while busy=0
//     hex_mode  1         1 = hex digits, 0 = decimal (sampled with data_in)
//     blank_lz  1         1 = blank leading zeros (sampled with data_in)
//     dp_mask   N_DIGITS  bit i lights the dp of digit i (sampled with data_in)
//     busy      1         conversion in progress
//     seg_com   N_DIGITS  active-low digit enables, digit i on bit N_DIGITS-1-i
//     seg_disp  8         {a,b,c,d,e,f,g,dp}, active-high
//     dbg_state 2         conversion FSM state (0 idle, 1 shift, 2 commit)
//
//   Handshake: a transfer happens on a rising clk edge where load=1 and
//   busy=0; load while busy=1 is dropped with no side effects.
// ----------------------------------------------------------------------------
interface seg_scan_mux_if #(
  parameter int DATA_W   = 16,
  parameter int N_DIGITS = 6
);
  logic [DATA_W-1:0]   data_in;
  logic                load;
  logic                hex_mode;
  logic                blank_lz;
  logic [N_DIGITS-1:0] dp_mask;
  logic                busy;
  logic [N_DIGITS-1:0] seg_com;
  logic [7:0]          seg_disp;
  logic [1:0]          dbg_state;

  modport master (
    output data_in, load, hex_mode, blank_lz, dp_mask,
    input  busy, seg_com, seg_disp, dbg_state
  );

  modport slave (
    input  data_in, load, hex_mode, blank_lz, dp_mask,
    output busy, seg_com, seg_disp, dbg_state
  );
endinterface

// File: rtl/seg_scan_mux.sv
// ----------------------------------------------------------------------------
// seg_scan_mux
//   Multiplexed common-anode 7-segment driver. A binary value is latched on
//   an accepted load and converted MSB-first, one bit per cycle, by a
//   double-dabble engine (or a plain nibble shift in hex mode). The finished
//   result is committed atomically into display registers, which a free
//   running scanner renders one digit at a time.
//
//   Parameters
//     DATA_W    width of the binary input (>= 4)
//     N_DIGITS  number of digits driven (1..8)
//     DIV       clk cycles each digit stays active (>= 1)
//
//   Ports
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    seg_scan_mux_if.slave (load bus in, segment/common pins out)
//
//   The interface instance must be built with the same DATA_W / N_DIGITS.
// ----------------------------------------------------------------------------
module seg_scan_mux #(
  parameter int DATA_W   = 16,
  parameter int N_DIGITS = 6,
  parameter int DIV      = 1000
) (
  input  logic           clk,
  input  logic           reset,
  seg_scan_mux_if.slave  bus
);

  localparam int ACC_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Conversion side
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                hex_q, hex_d;
  logic                blz_q, blz_d;
  logic [N_DIGITS-1:0] dp_q, dp_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_adj;

  // Display registers: only ever written in COMMIT, so the scanner never
  // sees a half-converted value.
  logic [ACC_W-1:0]    disp_acc_q, disp_acc_d;
  logic                disp_blz_q, disp_blz_d;
  logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                disp_ovf_q, disp_ovf_d;

  // Scanner
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_DIGITS-1:0] seg_com_q, seg_com_d;
  logic [7:0]          seg_disp_q, seg_disp_d;

  // Render helpers
  logic [3:0]          nib_sel;
  logic                dp_sel;
  logic                blank_sel;
  logic [N_DIGITS-1:0] lz;
  logic                above_zero;

  // --------------------------------------------------------------------------
  // Glyph table, {a,b,c,d,e,f,g}
  // --------------------------------------------------------------------------
  function automatic logic [6:0] glyph7(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'b1111110;
      4'h1:    g = 7'b0110000;
      4'h2:    g = 7'b1101101;
      4'h3:    g = 7'b1111001;
      4'h4:    g = 7'b0110011;
      4'h5:    g = 7'b1011011;
      4'h6:    g = 7'b1011111;
      4'h7:    g = 7'b1110000;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1111011;
      4'hA:    g = 7'b1110111;
      4'hB:    g = 7'b0011111;
      4'hC:    g = 7'b1001110;
      4'hD:    g = 7'b0111101;
      4'hE:    g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  // --------------------------------------------------------------------------
  // Conversion FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      hex_q      <= 1'b0;
      blz_q      <= 1'b0;
      dp_q       <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      disp_acc_q <= '0;
      disp_blz_q <= 1'b0;
      disp_dp_q  <= '0;
      disp_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      hex_q      <= hex_d;
      blz_q      <= blz_d;
      dp_q       <= dp_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      disp_acc_q <= disp_acc_d;
      disp_blz_q <= disp_blz_d;
      disp_dp_q  <= disp_dp_d;
      disp_ovf_q <= disp_ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Conversion FSM: next state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    hex_d      = hex_q;
    blz_d      = blz_q;
    dp_d       = dp_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    disp_acc_d = disp_acc_q;
    disp_blz_d = disp_blz_q;
    disp_dp_d  = disp_dp_q;
    disp_ovf_d = disp_ovf_q;
    acc_adj    = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          data_d  = bus.data_in;
          hex_d   = bus.hex_mode;
          blz_d   = bus.blank_lz;
          dp_d    = bus.dp_mask;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Decimal: add-3 correction on every nibble >= 5 before the shift.
        if (!hex_q) begin
          for (int i = 0; i < N_DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
              acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
          end
        end
        // A 1 leaving the top nibble means the value does not fit in
        // N_DIGITS digits (decimal) or has bits above 4*N_DIGITS (hex).
        ovf_d  = ovf_q | acc_adj[ACC_W-1];
        acc_d  = {acc_adj[ACC_W-2:0], data_q[DATA_W-1]};
        data_d = data_q << 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        disp_acc_d = acc_q;
        disp_blz_d = blz_q;
        disp_dp_d  = dp_q;
        disp_ovf_d = ovf_q;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Scanner: prescaler, digit index and registered pin outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q      <= '0;
      idx_q      <= '0;
      seg_com_q  <= '1;
      seg_disp_q <= 8'h00;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      seg_com_q  <= seg_com_d;
      seg_disp_q <= seg_disp_d;
    end
  end

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_W'(DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // lz[i] is set when digit i and every digit above it are zero.
  always_comb begin
    lz         = '0;
    above_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      above_zero = above_zero & (disp_acc_q[4*i +: 4] == 4'd0);
      lz[i]      = above_zero;
    end
  end

  // Pin outputs are built from the current index, so they follow an index
  // change by exactly one cycle.
  always_comb begin
    nib_sel   = 4'd0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    seg_com_d = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        nib_sel                 = disp_acc_q[4*i +: 4];
        dp_sel                  = disp_dp_q[i];
        // Digit 0 is never blanked so a zero value still shows "0".
        blank_sel               = disp_blz_q && lz[i] && (i != 0);
        seg_com_d[N_DIGITS-1-i] = 1'b0;
      end
    end

    if (disp_ovf_q) begin
      seg_disp_d = {7'b0000001, dp_sel};
    end else if (blank_sel) begin
      seg_disp_d = {7'b0000000, dp_sel};
    end else begin
      seg_disp_d = {glyph7(nib_sel), dp_sel};
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.seg_com   = seg_com_q;
  assign bus.seg_disp  = seg_disp_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_mux
//   Two instances share clk/reset: a six-digit driver and a four-digit one
//   (for overflow cases), both with DIV=4. Expected pin values come from
//   hand-written vectors or from a digit-arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_seg_scan_mux;

  localparam int DATA_W = 16;
  localparam int DIV    = 4;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  seg_scan_mux_if #(.DATA_W(DATA_W), .N_DIGITS(6)) if6 ();
  seg_scan_mux_if #(.DATA_W(DATA_W), .N_DIGITS(4)) if4 ();

  seg_scan_mux #(.DATA_W(DATA_W), .N_DIGITS(6), .DIV(DIV)) dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (if6)
  );

  seg_scan_mux #(.DATA_W(DATA_W), .N_DIGITS(4), .DIV(DIV)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4)
  );

  // --------------------------------------------------------------------------
  // Clock / reset bookkeeping
  // --------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Number of non-reset rising edges since reset was released.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic logic [6:0] glyph(input int v);
    case (v)
      0:  return 7'b1111110;
      1:  return 7'b0110000;
      2:  return 7'b1101101;
      3:  return 7'b1111001;
      4:  return 7'b0110011;
      5:  return 7'b1011011;
      6:  return 7'b1011111;
      7:  return 7'b1110000;
      8:  return 7'b1111111;
      9:  return 7'b1111011;
      10: return 7'b1110111;
      11: return 7'b0011111;
      12: return 7'b1001110;
      13: return 7'b0111101;
      14: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input int unsigned value, input bit hx,
                                           input bit bz, input logic [7:0] dp,
                                           input int nd, input int d);
    longint unsigned base, p, full;
    logic [6:0] g;
    base = hx ? 64'd16 : 64'd10;
    p = 1;
    for (int k = 0; k < d; k++) p = p * base;
    full = 1;
    for (int k = 0; k < nd; k++) full = full * base;
    if (value >= full)                 g = 7'b0000001;
    else if (bz && d > 0 && value < p) g = 7'b0000000;
    else                               g = glyph(int'((value / p) % base));
    return {g, dp[d]};
  endfunction

  function automatic logic [63:0] model_frame(input int unsigned value, input bit hx,
                                              input bit bz, input logic [7:0] dp,
                                              input int nd);
    logic [63:0] f;
    f = '0;
    for (int d = 0; d < nd; d++) f[8*d +: 8] = model_seg(value, hx, bz, dp, nd, d);
    return f;
  endfunction

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic drive(input bit sel, input logic [15:0] v, input bit hx,
                       input bit bz, input logic [7:0] dp, input bit ld);
    if (sel) begin
      if4.data_in = v; if4.hex_mode = hx; if4.blank_lz = bz;
      if4.dp_mask = dp[3:0]; if4.load = ld;
    end else begin
      if6.data_in = v; if6.hex_mode = hx; if6.blank_lz = bz;
      if6.dp_mask = dp[5:0]; if6.load = ld;
    end
  endtask

  task automatic set_load(input bit sel, input bit ld);
    if (sel) if4.load = ld;
    else     if6.load = ld;
  endtask

  function automatic logic get_busy(input bit sel);
    return sel ? if4.busy : if6.busy;
  endfunction

  function automatic logic [7:0] obs_com(input bit sel);
    return sel ? {4'b0, if4.seg_com} : {2'b0, if6.seg_com};
  endfunction

  function automatic logic [7:0] obs_disp(input bit sel);
    return sel ? if4.seg_disp : if6.seg_disp;
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Loads a value, measures busy, optionally pokes a second load mid-flight,
  // and returns once the committed value is on the pins.
  task automatic do_load(input bit sel, input logic [15:0] v, input bit hx,
                         input bit bz, input logic [7:0] dp,
                         input int poke_at, input logic [15:0] poke_v);
    int n;
    @(negedge clk);
    drive(sel, v, hx, bz, dp, 1'b1);
    @(negedge clk);
    // Scramble the bus so anything not latched at the load shows up.
    drive(sel, 16'($urandom), ~hx, ~bz, ~dp, 1'b0);
    n = 0;
    while (get_busy(sel) && n < 100) begin
      n++;
      if (poke_at != 0 && n == poke_at) drive(sel, poke_v, hx, bz, dp, 1'b1);
      @(negedge clk);
      set_load(sel, 1'b0);
    end
    check("busy_len", n, DATA_W + 1);
    @(negedge clk);
  endtask

  // Checks one full frame cycle by cycle. The digit on the pins after rising
  // edge k is floor((k-1)/DIV) mod nd.
  task automatic check_frame(input bit sel, input int nd, input logic [63:0] exp_flat,
                             input string tag);
    int d;
    logic [7:0] ec;
    for (int k = 0; k < nd * DIV; k++) begin
      d  = ((cyc - 1) / DIV) % nd;
      ec = 8'((1 << nd) - 1);
      ec[nd - 1 - d] = 1'b0;
      check(tag, {16'b0, obs_com(sel), obs_disp(sel)}, {16'b0, ec, exp_flat[8*d +: 8]});
      @(negedge clk);
    end
  endtask

  // --------------------------------------------------------------------------
  // Vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic [15:0] data;
    bit          hx;
    bit          bz;
    logic [7:0]  dp;
    logic [47:0] exp;   // digit 5 in the top byte, digit 0 in the bottom
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [63:0] ef;
    int unsigned rv;
    bit rh, rb;
    logic [7:0] rdp;

    checks = 0;
    errors = 0;
    vecs[0] = '{16'd12345, 1'b0, 1'b0, 8'b000000, 48'hFC_60_DA_F2_66_B6};
    vecs[1] = '{16'hBEEF,  1'b1, 1'b1, 8'b000100, 48'h00_00_3E_9F_9E_8E};
    vecs[2] = '{16'd0,     1'b0, 1'b1, 8'b000000, 48'h00_00_00_00_00_FC};
    vecs[3] = '{16'd65535, 1'b0, 1'b1, 8'b100001, 48'h01_BE_B6_B6_F2_B7};
    vecs[4] = '{16'h0007,  1'b1, 1'b0, 8'b000000, 48'hFC_FC_FC_FC_FC_E0};
    vecs[5] = '{16'd100,   1'b0, 1'b1, 8'b000010, 48'h00_00_00_60_FD_FC};
    vecs[6] = '{16'h0A0C,  1'b1, 1'b1, 8'b000000, 48'h00_00_00_EE_FC_9C};

    reset = 1'b1;
    drive(1'b0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 16'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_com6",  {24'b0, obs_com(1'b0)},  32'h3F);
    check("rst_disp6", {24'b0, obs_disp(1'b0)}, 32'h00);
    check("rst_busy6", {31'b0, if6.busy},       32'h0);
    check("rst_com4",  {24'b0, obs_com(1'b1)},  32'h0F);
    check("rst_busy4", {31'b0, if4.busy},       32'h0);

    reset = 1'b0;
    @(negedge clk);
    check("first_com",  {24'b0, obs_com(1'b0)},  32'h1F);
    check("first_disp", {24'b0, obs_disp(1'b0)}, 32'hFC);
    check_frame(1'b0, 6, 64'h0000_FCFC_FCFC_FCFC, "frame_rst");

    // Table-driven vectors on the six-digit driver
    for (int i = 0; i < 7; i++) begin
      do_load(1'b0, vecs[i].data, vecs[i].hx, vecs[i].bz, vecs[i].dp, 0, 16'd0);
      check_frame(1'b0, 6, {16'b0, vecs[i].exp}, $sformatf("vec%0d", i));
    end

    // Four digits: overflow shows dashes, dp still follows the mask
    do_load(1'b1, 16'd12345, 1'b0, 1'b0, 8'h0, 0, 16'd0);
    check_frame(1'b1, 4, 64'h0202_0202, "ovf_12345");
    do_load(1'b1, 16'd9999, 1'b0, 1'b0, 8'h0, 0, 16'd0);
    check_frame(1'b1, 4, 64'hF6F6_F6F6, "fit_9999");
    do_load(1'b1, 16'd10000, 1'b0, 1'b1, 8'b1001, 0, 16'd0);
    check_frame(1'b1, 4, 64'h0302_0203, "ovf_10000_dp");

    // Load while busy is dropped; busy length is unchanged
    do_load(1'b0, 16'd500, 1'b0, 1'b0, 8'h0, 5, 16'd777);
    check_frame(1'b0, 6, 64'h0000_FCFC_FCB6_FCFC, "ignore_777");

    // Reset in the middle of SHIFT aborts without committing
    @(negedge clk);
    drive(1'b0, 16'd65535, 1'b0, 1'b0, 8'h0, 1'b1);
    @(negedge clk);
    set_load(1'b0, 1'b0);
    repeat (7) @(negedge clk);
    check("abort_busy_before", {31'b0, if6.busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, if6.busy},       32'h0);
    check("abort_com",  {24'b0, obs_com(1'b0)},  32'h3F);
    check("abort_disp", {24'b0, obs_disp(1'b0)}, 32'h00);
    // load during reset must also be ignored
    drive(1'b0, 16'd4321, 1'b0, 1'b0, 8'h0, 1'b1);
    @(negedge clk);
    set_load(1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_busy", {31'b0, if6.busy},       32'h0);
    check("rel_com",  {24'b0, obs_com(1'b0)},  32'h1F);
    check("rel_disp", {24'b0, obs_disp(1'b0)}, 32'hFC);
    repeat (DATA_W + 4) @(negedge clk);
    check_frame(1'b0, 6, 64'h0000_FCFC_FCFC_FCFC, "no_commit");

    // Randomised loads against the reference model
    for (int i = 0; i < 16; i++) begin
      rv  = $urandom_range(0, 65535);
      rh  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      rdp = 8'($urandom_range(0, 63));
      do_load(1'b0, 16'(rv), rh, rb, rdp, 0, 16'd0);
      ef = model_frame(rv, rh, rb, rdp, 6);
      check_frame(1'b0, 6, ef, "rand6");
    end
    for (int i = 0; i < 10; i++) begin
      rv  = (i % 2 == 0) ? $urandom_range(0, 65535) : $urandom_range(9000, 11000);
      rh  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      rdp = 8'($urandom_range(0, 15));
      do_load(1'b1, 16'(rv), rh, rb, rdp, 0, 16'd0);
      ef = model_frame(rv, rh, rb, rdp, 4);
      check_frame(1'b1, 4, ef, "rand4");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised multiplexed 7-segment display driver and the successor to the fixed six-digit scanner. It latches a binary value on a load strobe and converts it with a sequential double-dabble engine (one bit per cycle) instead of combinational divide/modulo. The block then scans `N_DIGITS` common-anode digits at a programmable rate. It adds hex mode, leading-zero blanking, per-digit decimal points and overflow indication. It sits between the register/host interface and the board's segment/common pins.

## Interface
- `DATA_W`, 16, width of binary input (≥4)
- `N_DIGITS`, 6, number of digits driven (1..8)
- `DIV`, 1000, clk cycles each digit is held active (≥1)
- `clk`  input  1  system clock, all logic on rising edge
- `reset`  input  1  synchronous, active-high reset
- `data_in`  input  DATA_W  binary value, sampled on accepted `load`
- `load`  input  1  one-cycle start strobe; accepted only when `busy`=0
- `hex_mode`  input  1  sampled with `data_in`; 1 = hex digits, 0 = decimal
- `blank_lz`  input  1  sampled with `data_in`; 1 = blank leading zeros
- `dp_mask`  input  N_DIGITS  sampled with `data_in`; bit i lights the dp of digit i
- `busy`  output  1  conversion in progress
- `seg_com`  output  N_DIGITS  digit enables, active-low; digit i (0 = least significant) drives `seg_com[N_DIGITS-1-i]`
- `seg_disp`  output  8  {a,b,c,d,e,f,g,dp}, active-high

## Operation
- Conversion FSM:
  - IDLE: `load`=1 captures `data_in`, `hex_mode`, `blank_lz`, `dp_mask` into shadow registers, clears the BCD accumulator and overflow flag, and moves to SHIFT.
  - SHIFT: runs exactly DATA_W cycles, MSB first.
    - Decimal mode: each cycle adds 3 to every BCD nibble ≥5, then shifts left one bit taking the next data bit.
    - Any 1 shifted out of the top nibble (4·N_DIGITS bits) sets overflow.
    - Hex mode: plain shift with no add-3.
    - Hex overflow: any nonzero bit of data beyond 4·N_DIGITS bits.
  - COMMIT: one cycle; copies the accumulator, flags and mask into the display registers atomically, then returns to IDLE.
- `load` while `busy`=1 is ignored, and the in-flight conversion is unaffected.
- The display always shows the last committed value; no partial results ever appear.
- Glyphs (a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - dash=0000001, blank=0000000
- Overflow: every digit shows dash; dp follows the mask.
- Leading-zero blanking:
  - With `blank_lz`=1, digits above the most significant nonzero digit show blank.
  - Digit 0 is never blanked, so the value 0 shows "0".
  - A blanked digit still shows its dp when its mask bit is set.
- Scan:
  - A prescaler counts 0..DIV-1.
  - On terminal count the digit index advances, wrapping N_DIGITS-1 → 0.
  - Exactly one `seg_com` bit is low at all times after the first scan cycle.

## Timing
- Reset values:
  - `busy`=0, FSM=IDLE
  - `seg_com`=all ones, `seg_disp`=8'h00
  - Prescaler=0, digit index=0
  - Display registers hold value 0 with no blanking, dp mask 0, no overflow
- Load accepted at edge t:
  - `busy`=1 from t+1 through t+DATA_W+1 (SHIFT plus COMMIT).
  - `busy`=0 at t+DATA_W+2.
  - Display registers update at edge t+DATA_W+1.
  - A new `load` is accepted at the earliest at edge t+DATA_W+2.
- Latency: DATA_W+2 cycles from load to idle.
- `seg_com`/`seg_disp` are registered and change together on the same edge, one cycle after the index changes.
- Each digit is held exactly DIV cycles; one full frame is N_DIGITS·DIV cycles.
- With DIV=1 the digit changes every cycle.
- Reset mid-conversion aborts: FSM goes to IDLE, the display returns to the reset value, and no commit occurs.
- `load` asserted in the same cycle as `reset` is ignored.

## Test plan
- Reset (DATA_W=16, N_DIGITS=6, DIV=4) → `seg_com`=6'b111111, `seg_disp`=8'h00, `busy`=0. One cycle after reset release `seg_com`=6'b011111, digit 0 shows 0, `seg_disp`=8'b11111100.
- Load 12345, decimal, `blank_lz`=0, `dp_mask`=0 → `busy` high exactly 17 cycles. Next frame shows 5,4,3,2,1,0: digit 0 `seg_disp`=8'b10110110 on `seg_com`=6'b011111, and digit 5 shows 0 on 6'b111110. Each digit held 4 cycles, frame = 24 cycles.
- Load 16'hBEEF, `hex_mode`=1, `blank_lz`=1, `dp_mask`=6'b000100 → digits F,E,E,b, digits 4–5 blank (8'h00). Digit 2 shows E with dp set: 8'b10011111.
- Parameter N_DIGITS=4: load 12345 decimal → all four digits show dash (8'b00000010). Then load 9999 → 9,9,9,9, no dash.
- Load 500, then pulse `load` with 777 on cycle 5 of the conversion → 777 is ignored, display shows 500.
- Load 65535, assert `reset` at cycle 8 of SHIFT → outputs at reset values, the previous value is not shown, and `busy`=0 next cycle.
